imem_responder: RTL and testbench

- Memory-side responder for the fetch stage's instruction request interface.
- Accepts a word-aligned 16-bit instruction address and returns the 16-bit instruction after a fixed, parameterised latency.
- Signals stall while busy and pulses done with data.
- Replaces the single-cycle instruction memory so fetch can be exercised against multi-cycle memory; includes a load port for preloading program images.

---
 rtl/imem_responder_pkg.sv | 22 ++
 rtl/imem_responder_if.sv | 27 ++
 rtl/imem_array.sv | 28 ++
 rtl/imem_responder.sv | 137 +++++++++++++
 tb/tb_imem_responder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the multi-cycle instruction memory responder.
package imem_responder_pkg;

  localparam int LAT_DEFAULT = 2;
  localparam int WORD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // WAIT counts down to zero, so the first edge of WAIT is already one cycle of latency
  function automatic logic [3:0] wait_count_init(input int lat);
    if (lat > 1) begin
      return 4'(lat - 2);
    end else begin
      return 4'd0;
    end
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-to-memory request/response bundle with preload port.
interface imem_responder_if #(
  parameter int AW = 16
);
  import imem_responder_pkg::*;

  logic              req;
  logic [AW-1:0]     addr;
  logic              ld_en;
  logic [AW-1:0]     ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic [WORD_W-1:0] rdata;
  logic              done;
  logic              stall;
  logic              err;

  modport master (
    output req, addr, ld_en, ld_addr, ld_data,
    input  rdata, done, stall, err
  );

  modport slave (
    input  req, addr, ld_en, ld_addr, ld_data,
    output rdata, done, stall, err
  );

endinterface

// File: rtl/imem_array.sv
// Word-indexed instruction storage: synchronous write, combinational read.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-2:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-2:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** (AW - 1);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Preload write port; contents survive reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction memory responder: stalls fetch for LAT cycles, then pulses done.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT,
  parameter int AW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  imem_responder_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [AW-2:0]     r_widx;
  logic [AW-2:0]     w_widx_nxt;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] w_rdata_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_stall;
  logic              w_stall_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_we;
  logic              w_accept;
  logic [AW-2:0]     w_raddr;
  logic [WORD_W-1:0] w_arr_rdata;
  logic              w_unused_ld_bit;

  assign w_unused_ld_bit = bus.ld_addr[0];

  imem_array #(.AW(AW)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (bus.ld_addr[AW-1:1]),
    .i_wdata (bus.ld_data),
    .i_raddr (w_raddr),
    .o_rdata (w_arr_rdata)
  );

  // Next-state and next-output logic; acceptance is shared by IDLE and RESP
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_widx_nxt  = r_widx;
    w_rdata_nxt = r_rdata;
    w_done_nxt  = 1'b0;
    w_stall_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    w_accept    = 1'b0;
    w_raddr     = bus.addr[AW-1:1];

    case (r_state)
      ST_IDLE: begin
        if (bus.ld_en) begin
          w_we = 1'b1;
        end else begin
          w_accept = bus.req;
        end
      end
      ST_WAIT: begin
        w_raddr = r_widx;
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_done_nxt  = 1'b1;
          w_rdata_nxt = w_arr_rdata;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_stall_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.req) begin
          w_accept = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Misaligned requests answer immediately with err and never touch the array
    if (w_accept) begin
      if (bus.addr[0]) begin
        w_state_nxt = ST_RESP;
        w_done_nxt  = 1'b1;
        w_err_nxt   = 1'b1;
        w_rdata_nxt = {WORD_W{1'b0}};
      end else if (LAT == 1) begin
        w_state_nxt = ST_RESP;
        w_done_nxt  = 1'b1;
        w_widx_nxt  = bus.addr[AW-1:1];
        w_rdata_nxt = w_arr_rdata;
      end else begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = wait_count_init(LAT);
        w_stall_nxt = 1'b1;
        w_widx_nxt  = bus.addr[AW-1:1];
      end
    end else begin
      w_widx_nxt = w_widx_nxt;
    end
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_widx  <= {(AW-1){1'b0}};
      r_rdata <= {WORD_W{1'b0}};
      r_done  <= 1'b0;
      r_stall <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_widx  <= w_widx_nxt;
      r_rdata <= w_rdata_nxt;
      r_done  <= w_done_nxt;
      r_stall <= w_stall_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.done  = r_done;
  assign bus.stall = r_stall;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder (LAT=2 and LAT=1 instances).
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel;
  logic        req;
  logic        ld_en;
  logic [15:0] addr;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  always #5 clk = ~clk;

  imem_responder_if #(.AW(16)) bus_a ();
  imem_responder_if #(.AW(16)) bus_b ();

  assign bus_a.req     = req & ~sel;
  assign bus_a.ld_en   = ld_en & ~sel;
  assign bus_a.addr    = addr;
  assign bus_a.ld_addr = ld_addr;
  assign bus_a.ld_data = ld_data;
  assign bus_b.req     = req & sel;
  assign bus_b.ld_en   = ld_en & sel;
  assign bus_b.addr    = addr;
  assign bus_b.ld_addr = ld_addr;
  assign bus_b.ld_data = ld_data;

  imem_responder #(.LAT(2), .AW(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  imem_responder #(.LAT(1), .AW(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [15:0] o_rdata;
  logic        o_done;
  logic        o_stall;
  logic        o_err;

  assign o_rdata = sel ? bus_b.rdata : bus_a.rdata;
  assign o_done  = sel ? bus_b.done  : bus_a.done;
  assign o_stall = sel ? bus_b.stall : bus_a.stall;
  assign o_err   = sel ? bus_b.err   : bus_a.err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference memory per instance, keyed by instance and word index
  logic [15:0] mdl [int];
  logic [15:0] pool [8];
  logic [15:0] ra;
  bit          pend;
  int          r;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, act, exp, sel, $time);
    end
  endtask

  function automatic int key_of(input logic [15:0] a);
    return (sel ? 65536 : 0) + int'(a[15:1]);
  endfunction

  function automatic int lat_of_sel();
    return sel ? 1 : 2;
  endfunction

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    mdl[key_of(a)] = d;
    check_eq("load_nodone", 32'(o_done), 32'd0);
  endtask

  // Issue one read; responses are due exactly LAT cycles (1 if misaligned) after presenting req
  task automatic do_read(input logic [15:0] a, input bit keep, input bit junk);
    int          lat;
    logic [15:0] exp;
    lat = a[0] ? 1 : lat_of_sel();
    exp = a[0] ? 16'h0000 : mdl[key_of(a)];
    req  = 1'b1;
    addr = a;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      ld_en = 1'b0;
      if (k < lat) begin
        check_eq("wait_stall", 32'(o_stall), 32'd1);
        check_eq("wait_done", 32'(o_done), 32'd0);
        if (junk) begin
          ld_en   = 1'b1;
          ld_addr = a;
          ld_data = ~exp;
        end
      end else begin
        check_eq("resp_done", 32'(o_done), 32'd1);
        check_eq("resp_stall", 32'(o_stall), 32'd0);
        check_eq("resp_err", 32'(o_err), 32'(a[0]));
        check_eq("resp_rdata", 32'(o_rdata), 32'(exp));
      end
    end
    if (!keep) begin
      req = 1'b0;
      if (junk) begin
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = ~exp;
      end
      @(negedge clk);
      ld_en = 1'b0;
      check_eq("post_done", 32'(o_done), 32'd0);
      check_eq("post_stall", 32'(o_stall), 32'd0);
    end
  endtask

  initial begin
    sel = 1'b0; req = 1'b0; ld_en = 1'b0;
    addr = 16'h0000; ld_addr = 16'h0000; ld_data = 16'h0000;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_eq("rst_done", 32'(o_done), 32'd0);
      check_eq("rst_stall", 32'(o_stall), 32'd0);
      check_eq("rst_err", 32'(o_err), 32'd0);
      check_eq("rst_rdata", 32'(o_rdata), 32'd0);
    end
    sel = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    do_load(16'h0000, 16'h1234);
    do_load(16'h0002, 16'hABCD);
    do_read(16'h0000, 1'b0, 1'b0);
    do_read(16'h0000, 1'b1, 1'b0);
    do_read(16'h0002, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_eq("no_third_done", 32'(o_done), 32'd0);
    end
    do_read(16'h0003, 1'b0, 1'b0);

    // Reset while a request waits aborts it
    req = 1'b1; addr = 16'h0000;
    @(negedge clk);
    check_eq("mid_stall", 32'(o_stall), 32'd1);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check_eq("abort_stall", 32'(o_stall), 32'd0);
    check_eq("abort_done", 32'(o_done), 32'd0);
    check_eq("abort_err", 32'(o_err), 32'd0);
    check_eq("abort_rdata", 32'(o_rdata), 32'd0);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("abort_quiet", 32'(o_done), 32'd0);
    end
    do_read(16'h0000, 1'b0, 1'b0);

    // Load has priority over a simultaneous request in IDLE
    ld_en = 1'b1; ld_addr = 16'h0004; ld_data = 16'h5A5A;
    req = 1'b1; addr = 16'h0004;
    @(negedge clk);
    ld_en = 1'b0;
    mdl[key_of(16'h0004)] = 16'h5A5A;
    check_eq("ldreq_done", 32'(o_done), 32'd0);
    check_eq("ldreq_stall", 32'(o_stall), 32'd0);
    do_read(16'h0004, 1'b0, 1'b0);

    req = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    do_load(16'hFFFE, 16'hBEEF);
    do_read(16'hFFFE, 1'b0, 1'b0);

    pool[0] = 16'h0000;
    pool[1] = 16'hFFFE;
    for (int i = 2; i < 8; i++) pool[i] = 16'($urandom) & 16'hFFFE;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      for (int i = 0; i < 8; i++) do_load(pool[i] | 16'($urandom_range(0, 1)), 16'($urandom));
      pend = 1'b0;
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 9);
        if (!pend && r < 3) begin
          do_load(pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 1)), 16'($urandom));
        end else begin
          ra = pool[$urandom_range(0, 7)];
          if ($urandom_range(0, 7) == 0) ra[0] = 1'b1;
          pend = ($urandom_range(0, 2) == 0);
          do_read(ra, pend, 1'($urandom_range(0, 1)));
        end
      end
      if (pend) do_read(pool[0], 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
